// File: rtl/c499_sec_pkg.sv
// c499 SEC check-bit code: column codes and per-check data masks.
// Shared by the encoder top and its byte-parity slices.
package c499_sec_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam int CNT_W  = 16;
  localparam int NBYTE  = DATA_W / 8;

  typedef logic [CHK_W-1:0][DATA_W-1:0] mask_t;

  function automatic logic [CHK_W-1:0] col_code(
    input logic [4:0] i
  );
    logic [1:0]       a;
    logic [1:0]       b;
    logic [1:0]       bn;
    logic [CHK_W-1:0] c;
    a  = i[1:0];
    b  = i[4:3];
    bn = b + 2'd1;
    c  = '0;
    c[{1'b0, a}] = 1'b1;
    c[{1'b1, b}] = 1'b1;
    if (i[2]) c[{1'b1, bn}] = 1'b1;
    return c;
  endfunction

  function automatic mask_t gen_masks();
    mask_t            m;
    logic [CHK_W-1:0] c;
    m = '0;
    for (int i = 0; i < DATA_W; i++) begin
      c = col_code(5'(i));
      for (int j = 0; j < CHK_W; j++)
        m[j][i] = c[j];
    end
    return m;
  endfunction

  localparam mask_t CHK_MASK = gen_masks();

endpackage

// File: rtl/c499_byte_parity.sv
// One data byte's contribution to the 8 check bits.
// IDX selects which byte lane of the code matrix applies.
module c499_byte_parity
  import c499_sec_pkg::*;
#(
  parameter int unsigned IDX = 0
) (
  input  logic [7:0]       din,
  output logic [CHK_W-1:0] part
);

  // each check bit is the parity of the masked byte
  always_comb begin
    part = '0;
    for (int j = 0; j < CHK_W; j++)
      part[j] = ^(din & CHK_MASK[j][8*IDX +: 8]);
  end

endmodule

// File: rtl/c499_sec_encoder.sv
// Two-stage SEC check-bit encoder with valid/ready flow control.
// Optional C499_LOCK_KEY_EN xors key_i into the check bits.
module c499_sec_encoder
  import c499_sec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
`ifdef C499_LOCK_KEY_EN
  input  logic [CHK_W-1:0]  key_i,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_check,
  output logic [CNT_W-1:0]  word_cnt
);

  logic                        s1_valid;
  logic [DATA_W-1:0]           s1_data;
  logic [NBYTE-1:0][CHK_W-1:0] s1_part;
  logic [NBYTE-1:0][CHK_W-1:0] part;
  logic [CHK_W-1:0]            chk_next;
  logic                        s2_en;

  for (genvar g = 0; g < NBYTE; g++) begin : g_byte
    c499_byte_parity #(
      .IDX(g)
    ) u_bp (
      .din (in_data[8*g +: 8]),
      .part(part[g])
    );
  end

  assign s2_en    = !out_valid || out_ready;
  assign in_ready = s2_en || !s1_valid;

  // fold the byte partials into the final check bits
  always_comb begin
    chk_next = '0;
    for (int k = 0; k < NBYTE; k++)
      chk_next = chk_next ^ s1_part[k];
`ifdef C499_LOCK_KEY_EN
    chk_next = chk_next ^ key_i;
`endif
  end

  // stage 1: capture word and per-byte partial parities
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_part  <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= in_data;
        s1_part <= part;
      end
    end
  end

  // stage 2: output register, held while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_check <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data  <= s1_data;
        out_check <= chk_next;
      end
    end
  end

  // count words delivered downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      word_cnt <= '0;
    else if (out_valid && out_ready)
      word_cnt <= word_cnt + CNT_W'(1);
  end

endmodule
